// File: rtl/racer_pkg.sv
// racer_pkg
// Types and constants shared by the race-logic blocks (lap_tracker, the HUD
// renderer and the track-collision logic).
//   lap_state_t        : lap sequencer states
//   BEST_NONE          : best-lap value meaning "no valid lap yet"
//   NUM_CP_DEFAULT     : number of ordered checkpoints on the track
//   MAX_LAP_CS_DEFAULT : lap-time limit in 10 ms ticks
package racer_pkg;

  typedef enum logic [1:0] {
    LAP_IDLE,
    LAP_ARMED,
    LAP_RUNNING
  } lap_state_t;

  localparam logic [15:0] BEST_NONE          = 16'hFFFF;
  localparam int          NUM_CP_DEFAULT     = 4;
  localparam int          MAX_LAP_CS_DEFAULT = 6000;

endpackage

// File: rtl/rise_detect.sv
// rise_detect
// Per-bit rising-edge detector with a registered history of the inputs.
//   pclk : system clock
//   rst  : synchronous active-high reset, clears the history
//   sig  : level inputs, WIDTH bits
//   rise : high for bits that are high now and were low last cycle
module rise_detect #(
  parameter int WIDTH = 1
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge pclk) begin
    if (rst) prev <= '0;
    else     prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/lap_tracker.sv
// lap_tracker
// Race-lap sequencer: arms when gameplay starts, times laps in prescaled
// ticks, enforces ordered checkpoints, flags timeouts and keeps best lap
// and lap count for the HUD.
//   pclk, rst             : clock, synchronous active-high reset
//   race_active           : gameplay visible; low forces IDLE
//   finish_hit            : level, car over the start/finish line
//   cp_hit                : level per checkpoint
//   lap_finished          : 1-cycle pulse when a lap ends at the line
//   checkpoints_passed    : all checkpoints taken in order this lap
//   max_lap_time_exceeded : 1-cycle pulse when a lap times out
//   lap_time              : current lap time in ticks, saturates at MAX_LAP_CS
//   best_lap              : best valid lap, 16'hFFFF when none
//   lap_count             : valid laps completed, saturates at 15
//   next_cp               : index of the next expected checkpoint
module lap_tracker
  import racer_pkg::*;
#(
  parameter int TICK_DIV   = 650000,
  parameter int NUM_CP     = NUM_CP_DEFAULT,
  parameter int MAX_LAP_CS = MAX_LAP_CS_DEFAULT
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              race_active,
  input  logic              finish_hit,
  input  logic [NUM_CP-1:0] cp_hit,
  output logic              lap_finished,
  output logic              checkpoints_passed,
  output logic              max_lap_time_exceeded,
  output logic [15:0]       lap_time,
  output logic [15:0]       best_lap,
  output logic [3:0]        lap_count,
  output logic [2:0]        next_cp
);

  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]     LAP_LIMIT  = 16'(MAX_LAP_CS);
  // next_cp can reach NUM_CP (up to 8), so it is kept one bit wider inside.
  localparam logic [3:0]      CP_ALL     = 4'(NUM_CP);

  logic [NUM_CP:0]   edges;
  logic              fin_rise;
  logic [NUM_CP-1:0] cp_rise;
  logic              cp_expected;

  lap_state_t    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   lap_time_q, lap_time_d;
  logic [15:0]   best_q, best_d;
  logic [3:0]    count_q, count_d;
  logic [3:0]    next_cp_q, next_cp_d;
  logic          fin_pulse_q, fin_pulse_d;
  logic          timeout_q, timeout_d;
  logic          cp_done_q, cp_done_d;

  rise_detect #(.WIDTH(NUM_CP + 1)) u_rise (
    .pclk (pclk),
    .rst  (rst),
    .sig  ({finish_hit, cp_hit}),
    .rise (edges)
  );

  assign fin_rise = edges[NUM_CP];
  assign cp_rise  = edges[NUM_CP-1:0];

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= LAP_IDLE;
      presc_q     <= '0;
      lap_time_q  <= '0;
      best_q      <= BEST_NONE;
      count_q     <= '0;
      next_cp_q   <= '0;
      fin_pulse_q <= 1'b0;
      timeout_q   <= 1'b0;
      cp_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      lap_time_q  <= lap_time_d;
      best_q      <= best_d;
      count_q     <= count_d;
      next_cp_q   <= next_cp_d;
      fin_pulse_q <= fin_pulse_d;
      timeout_q   <= timeout_d;
      cp_done_q   <= cp_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    lap_time_d  = lap_time_q;
    best_d      = best_q;
    count_d     = count_q;
    next_cp_d   = next_cp_q;
    fin_pulse_d = 1'b0;
    timeout_d   = 1'b0;
    cp_expected = 1'b0;

    // Only the checkpoint currently expected may advance next_cp; once all
    // are taken no index matches, so the count stops at NUM_CP.
    for (int i = 0; i < NUM_CP; i++) begin
      if (cp_rise[i] && (next_cp_q == 4'(i))) cp_expected = 1'b1;
    end

    if (!race_active) begin
      state_d    = LAP_IDLE;
      presc_d    = '0;
      lap_time_d = '0;
      next_cp_d  = '0;
      count_d    = '0;
    end else begin
      case (state_q)
        LAP_IDLE: state_d = LAP_ARMED;
        LAP_ARMED: begin
          if (fin_rise) begin
            state_d    = LAP_RUNNING;
            presc_d    = '0;
            lap_time_d = '0;
            next_cp_d  = '0;
          end
        end
        LAP_RUNNING: begin
          // A line crossing ends the lap and wins over timeout and checkpoints.
          if (fin_rise) begin
            fin_pulse_d = 1'b1;
            if (next_cp_q == CP_ALL) begin
              if (count_q != 4'd15) count_d = count_q + 4'd1;
              if (lap_time_q < best_q) best_d = lap_time_q;
            end
            presc_d    = '0;
            lap_time_d = '0;
            next_cp_d  = '0;
          end else begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              if (lap_time_q + 16'd1 == LAP_LIMIT) begin
                timeout_d  = 1'b1;
                lap_time_d = LAP_LIMIT;
                next_cp_d  = '0;
                state_d    = LAP_ARMED;
              end else begin
                lap_time_d = lap_time_q + 16'd1;
              end
            end else begin
              presc_d = presc_q + 1'b1;
            end
            if (cp_expected && !timeout_d) next_cp_d = next_cp_q + 4'd1;
          end
        end
        default: state_d = LAP_IDLE;
      endcase
    end

    // On the lap_finished cycle the flag still reports the lap just ended.
    cp_done_d = fin_pulse_d ? (next_cp_q == CP_ALL) : (next_cp_d == CP_ALL);
  end

  assign lap_finished          = fin_pulse_q;
  assign checkpoints_passed    = cp_done_q;
  assign max_lap_time_exceeded = timeout_q;
  assign lap_time              = lap_time_q;
  assign best_lap              = best_q;
  assign lap_count             = count_q;
  assign next_cp               = next_cp_q[2:0];

endmodule

// File: tb/tb_lap_tracker.sv
// tb_lap_tracker
// Self-checking bench for lap_tracker with TICK_DIV=4, MAX_LAP_CS=20,
// NUM_CP=3. A behavioural model tracks laps as elapsed cycles and derives
// lap time by division; every cycle is compared against it, and directed
// scenarios pin the model with hand-computed values before a random phase.
module tb_lap_tracker;

  localparam int TD   = 4;
  localparam int NCP  = 3;
  localparam int MAXL = 20;

  logic           pclk = 1'b0;
  logic           rst;
  logic           race_active;
  logic           finish_hit;
  logic [NCP-1:0] cp_hit;
  logic           lap_finished;
  logic           checkpoints_passed;
  logic           max_lap_time_exceeded;
  logic [15:0]    lap_time;
  logic [15:0]    best_lap;
  logic [3:0]     lap_count;
  logic [2:0]     next_cp;

  lap_tracker #(.TICK_DIV(TD), .NUM_CP(NCP), .MAX_LAP_CS(MAXL)) dut (
    .pclk                  (pclk),
    .rst                   (rst),
    .race_active           (race_active),
    .finish_hit            (finish_hit),
    .cp_hit                (cp_hit),
    .lap_finished          (lap_finished),
    .checkpoints_passed    (checkpoints_passed),
    .max_lap_time_exceeded (max_lap_time_exceeded),
    .lap_time              (lap_time),
    .best_lap              (best_lap),
    .lap_count             (lap_count),
    .next_cp               (next_cp)
  );

  always #5 pclk = ~pclk;

  // Model state: mode 0 idle, 1 armed, 2 running.
  int           m_mode;
  bit           m_prev_fin;
  bit [NCP-1:0] m_prev_cp;
  int           m_elapsed;
  int           m_lap_time;
  int           m_next_cp;
  int           m_count;
  int           m_best;
  bit           m_fin;
  bit           m_to;
  bit           m_passed;

  int vectors     = 0;
  int miscompares = 0;

  task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Applies the rules of one clock edge to the model, using the inputs the
  // DUT samples on that same edge.
  task automatic modelStep();
    bit           fe;
    bit [NCP-1:0] ce;
    if (rst) begin
      m_mode = 0; m_prev_fin = 0; m_prev_cp = '0; m_elapsed = 0;
      m_lap_time = 0; m_next_cp = 0; m_count = 0; m_best = 65535;
      m_fin = 0; m_to = 0; m_passed = 0;
    end else begin
      fe = finish_hit && !m_prev_fin;
      ce = cp_hit & ~m_prev_cp;
      m_prev_fin = finish_hit;
      m_prev_cp  = cp_hit;
      m_fin = 0;
      m_to  = 0;
      if (!race_active) begin
        m_mode = 0; m_elapsed = 0; m_lap_time = 0; m_next_cp = 0; m_count = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (fe) begin
          m_mode = 2; m_elapsed = 0; m_lap_time = 0; m_next_cp = 0;
        end
      end else begin
        if (fe) begin
          m_fin = 1;
          m_passed = (m_next_cp == NCP);
          if (m_passed) begin
            if (m_count < 15) m_count++;
            if (m_lap_time < m_best) m_best = m_lap_time;
          end
          m_elapsed = 0; m_lap_time = 0; m_next_cp = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == MAXL * TD) begin
            m_to = 1; m_lap_time = MAXL; m_next_cp = 0; m_mode = 1;
          end else begin
            m_lap_time = m_elapsed / TD;
            if (m_next_cp < NCP && ce[m_next_cp]) m_next_cp++;
          end
        end
      end
      if (!m_fin) m_passed = (m_next_cp == NCP);
    end
  endtask

  task automatic checkOutput();
    checkOne("lap_finished", 32'(lap_finished), 32'(m_fin));
    checkOne("checkpoints_passed", 32'(checkpoints_passed), 32'(m_passed));
    checkOne("max_lap_time_exceeded", 32'(max_lap_time_exceeded), 32'(m_to));
    checkOne("lap_time", 32'(lap_time), m_lap_time);
    checkOne("best_lap", 32'(best_lap), m_best);
    checkOne("lap_count", 32'(lap_count), m_count);
    checkOne("next_cp", 32'(next_cp), m_next_cp);
  endtask

  // Drives one cycle of inputs, steps the model on the sampling edge and
  // compares on the following falling edge.
  task automatic applyStimulus(input bit rs, input bit ra, input bit fin, input logic [NCP-1:0] cp);
    rst         = rs;
    race_active = ra;
    finish_hit  = fin;
    cp_hit      = cp;
    @(posedge pclk);
    modelStep();
    @(negedge pclk);
    checkOutput();
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, '0);
    applyStimulus(1, 0, 0, '0);
  endtask

  task automatic pulseFinish();
    applyStimulus(0, 1, 1, '0);
    applyStimulus(0, 1, 0, '0);
  endtask

  task automatic pulseCp(input int idx);
    logic [NCP-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    applyStimulus(0, 1, 0, v);
    applyStimulus(0, 1, 0, '0);
  endtask

  task automatic waitLapTime(input int target);
    int g;
    g = 0;
    while (m_lap_time != target && g < 200) begin
      applyStimulus(0, 1, 0, '0);
      g++;
    end
    checkOne("wait_lap_time_bound", 32'(m_lap_time), target);
  endtask

  // Three ordered checkpoints, then the line is crossed at lap time t.
  task automatic validLap(input int t);
    pulseCp(0);
    pulseCp(1);
    pulseCp(2);
    waitLapTime(t);
    applyStimulus(0, 1, 1, '0);
    checkOne("valid_lap_finished", 32'(lap_finished), 32'd1);
    applyStimulus(0, 1, 0, '0);
  endtask

  initial begin
    int to_seen;
    int to_lap;
    int fin_seen;
    bit ra_r;
    bit fin_r;
    logic [NCP-1:0] cp_r;

    rst = 1'b1; race_active = 1'b0; finish_hit = 1'b0; cp_hit = '0;

    // Reset state
    doReset();
    checkOne("reset_lap_time", 32'(lap_time), 32'd0);
    checkOne("reset_best_lap", 32'(best_lap), 32'hFFFF);
    checkOne("reset_lap_count", 32'(lap_count), 32'd0);
    checkOne("reset_next_cp", 32'(next_cp), 32'd0);
    checkOne("reset_lap_finished", 32'(lap_finished), 32'd0);

    // Valid lap finishing at lap time 12
    applyStimulus(0, 1, 0, '0);
    pulseFinish();
    pulseCp(0);
    pulseCp(1);
    pulseCp(2);
    checkOne("valid_next_cp_all", 32'(next_cp), 32'd3);
    checkOne("valid_cp_passed_level", 32'(checkpoints_passed), 32'd1);
    waitLapTime(12);
    applyStimulus(0, 1, 1, '0);
    checkOne("valid_lap_finished", 32'(lap_finished), 32'd1);
    checkOne("valid_cp_passed", 32'(checkpoints_passed), 32'd1);
    checkOne("valid_best_lap", 32'(best_lap), 32'd12);
    checkOne("valid_lap_count", 32'(lap_count), 32'd1);
    checkOne("valid_lap_time_clear", 32'(lap_time), 32'd0);
    applyStimulus(0, 1, 0, '0);
    checkOne("valid_pulse_drop", 32'(lap_finished), 32'd0);
    checkOne("valid_cp_passed_drop", 32'(checkpoints_passed), 32'd0);

    // Out-of-order checkpoints
    doReset();
    applyStimulus(0, 1, 0, '0);
    pulseFinish();
    pulseCp(0);
    pulseCp(2);
    checkOne("ooo_next_cp", 32'(next_cp), 32'd1);
    applyStimulus(0, 1, 1, '0);
    checkOne("ooo_lap_finished", 32'(lap_finished), 32'd1);
    checkOne("ooo_cp_passed", 32'(checkpoints_passed), 32'd0);
    checkOne("ooo_lap_count", 32'(lap_count), 32'd0);
    checkOne("ooo_best_lap", 32'(best_lap), 32'hFFFF);

    // Timeout: no finish for 80 cycles after the lap restarts
    to_seen = 0;
    to_lap  = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 1, 0, '0);
      if (max_lap_time_exceeded === 1'b1) begin
        to_seen++;
        to_lap = 32'(lap_time);
      end
    end
    checkOne("timeout_pulse_count", to_seen, 32'd1);
    checkOne("timeout_lap_time", to_lap, 32'd20);
    pulseCp(0);
    checkOne("armed_cp_ignored", 32'(next_cp), 32'd0);
    checkOne("armed_lap_time_held", 32'(lap_time), 32'd20);

    // Held finish produces one lap_finished; finish beats a same-cycle cp
    pulseFinish();
    fin_seen = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(0, 1, 1, '0);
      if (lap_finished === 1'b1) fin_seen++;
    end
    checkOne("held_finish_pulses", fin_seen, 32'd1);
    applyStimulus(0, 1, 0, '0);
    applyStimulus(0, 1, 1, 3'b001);
    checkOne("simul_lap_finished", 32'(lap_finished), 32'd1);
    checkOne("simul_next_cp", 32'(next_cp), 32'd0);
    applyStimulus(0, 1, 0, '0);
    checkOne("simul_next_cp_after", 32'(next_cp), 32'd0);

    // Best-lap retention across laps of 15, 9, 18 and a race_active drop
    doReset();
    applyStimulus(0, 1, 0, '0);
    pulseFinish();
    validLap(15);
    checkOne("best_after_15", 32'(best_lap), 32'd15);
    validLap(9);
    checkOne("best_after_9", 32'(best_lap), 32'd9);
    validLap(18);
    checkOne("best_after_18", 32'(best_lap), 32'd9);
    checkOne("count_after_3", 32'(lap_count), 32'd3);
    applyStimulus(0, 0, 0, '0);
    applyStimulus(0, 0, 0, '0);
    checkOne("drop_lap_count", 32'(lap_count), 32'd0);
    checkOne("drop_lap_time", 32'(lap_time), 32'd0);
    checkOne("drop_best_kept", 32'(best_lap), 32'd9);

    // Mid-lap reset
    applyStimulus(0, 1, 0, '0);
    pulseFinish();
    pulseCp(0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, '0);
    applyStimulus(1, 1, 1, 3'b010);
    checkOne("rst_lap_time", 32'(lap_time), 32'd0);
    checkOne("rst_best_lap", 32'(best_lap), 32'hFFFF);
    checkOne("rst_lap_count", 32'(lap_count), 32'd0);
    checkOne("rst_next_cp", 32'(next_cp), 32'd0);
    checkOne("rst_lap_finished", 32'(lap_finished), 32'd0);
    checkOne("rst_timeout", 32'(max_lap_time_exceeded), 32'd0);
    checkOne("rst_cp_passed", 32'(checkpoints_passed), 32'd0);

    // Random phase against the model
    ra_r  = 1'b1;
    fin_r = 1'b0;
    cp_r  = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) ra_r = ~ra_r;
      if (!ra_r && $urandom_range(0, 9) == 0) ra_r = 1'b1;
      if ($urandom_range(0, 29) == 0) fin_r = ~fin_r;
      for (int b = 0; b < NCP; b++) begin
        if ($urandom_range(0, 5) == 0) cp_r[b] = ~cp_r[b];
      end
      applyStimulus($urandom_range(0, 499) == 0, ra_r, fin_r, cp_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lap_tracker.md
# lap_tracker

Race-lap sequencer between the track collision logic and `main_fsm`. It arms on entry to gameplay, times each lap in 10 ms units, enforces ordered checkpoint passage, and detects lap timeouts. It drives `main_fsm`'s `lap_finished`, `checkpoints_passed` and `max_lap_time_exceeded` inputs, and feeds lap time, best lap and lap count to the HUD renderer.

## Interface

- `TICK_DIV`, 650000: `pclk` cycles per lap-time unit (10 ms at 65 MHz).
- `NUM_CP`, 4: number of ordered checkpoints, 1..8.
- `MAX_LAP_CS`, 6000: lap-time limit in ticks.

Ports:

- `pclk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `race_active` in 1: tie to `main_fsm.game_visible`. Low forces IDLE.
- `finish_hit` in 1: level, car over the start/finish line.
- `cp_hit` in `NUM_CP`: level per checkpoint, car over checkpoint i.
- `lap_finished` out 1: one-cycle pulse on each finish-line crossing that ends a lap.
- `checkpoints_passed` out 1: level, all `NUM_CP` checkpoints taken in order in the current lap.
- `max_lap_time_exceeded` out 1: one-cycle pulse when a lap times out.
- `lap_time` out 16: current lap time in ticks. Saturates at `MAX_LAP_CS`.
- `best_lap` out 16: best valid lap. 16'hFFFF means none yet.
- `lap_count` out 4: valid laps completed. Saturates at 15.
- `next_cp` out 3: index of the next expected checkpoint.

## Operation

- A rising edge is input high now and low the previous cycle. Only rising edges of `finish_hit` and `cp_hit[i]` count. Held levels are ignored.
- States:
  - **IDLE**: all counters held at 0.
  - **ARMED**: waiting for the first finish crossing.
  - **RUNNING**: lap in progress.
- Transitions:
  - IDLE→ARMED when `race_active` = 1.
  - Any state→IDLE when `race_active` = 0. This clears `lap_time`, `next_cp`, `lap_count` and the prescaler. `best_lap` is retained.
  - ARMED→RUNNING on a finish edge. `lap_time`, prescaler and `next_cp` are cleared. No `lap_finished` pulse.
- RUNNING, checkpoint edge:
  - An edge on `cp_hit[next_cp]` increments `next_cp`, up to `NUM_CP`.
  - Edges on any other checkpoint are ignored, including repeats and out-of-order hits.
  - `checkpoints_passed` = (`next_cp` == `NUM_CP`).
- RUNNING, finish edge:
  - `lap_finished` pulses.
  - If `next_cp` == `NUM_CP` the lap is valid: `lap_count` is incremented, and `best_lap` is updated if `lap_time` < `best_lap`.
  - In all cases `lap_time`, prescaler and `next_cp` are cleared and the state stays RUNNING.
- RUNNING, timeout:
  - The prescaler wraps at `TICK_DIV`-1 and increments `lap_time`.
  - When the increment would make `lap_time` = `MAX_LAP_CS`, `max_lap_time_exceeded` pulses, `lap_time` holds at `MAX_LAP_CS`, `next_cp` is cleared, and the state goes to ARMED. The player must recross the line to restart.
- Priorities within one cycle:
  - Finish edge beats timeout. The lap ends normally.
  - Finish edge beats checkpoint edge. The checkpoint edge is discarded.
  - `race_active` = 0 beats everything.

## Timing

- Reset values:
  - state IDLE
  - `lap_finished`, `checkpoints_passed`, `max_lap_time_exceeded` = 0
  - `lap_time` = 0, `lap_count` = 0, `next_cp` = 0
  - `best_lap` = 16'hFFFF
  - edge-history registers = 0
- All outputs are registered.
- Edge at input in cycle t: the response is visible at cycle t+1.
- `lap_finished` and `max_lap_time_exceeded` are high for exactly one cycle and are never high together.
- During the `lap_finished` cycle, `checkpoints_passed` holds the value from the lap just ended. It drops to 0 the following cycle.
- `lap_time`, `best_lap` and `lap_count` update in the same cycle as `lap_finished`.
- `rst` asserted mid-lap takes effect at the next edge and overrides all other inputs.

## Structure

- `racer_pkg` holds:
  - the lap-state enum (IDLE, ARMED, RUNNING)
  - `BEST_NONE` = 16'hFFFF
  - the `NUM_CP` default and `MAX_LAP_CS` default, shared with the HUD and track-collision blocks
- One sub-module, `rise_detect`: parameterised width, registered history, outputs `in & ~prev`. It is instantiated once for `{finish_hit, cp_hit}`.

## Test plan

Common setup: `TICK_DIV`=4, `MAX_LAP_CS`=20, `NUM_CP`=3.

- **Valid lap.** Raise `race_active`, then a finish edge, then cp0, cp1, cp2 edges, then a finish edge at `lap_time`=12. Required: `lap_finished` for 1 cycle with `checkpoints_passed`=1, `best_lap`=12, `lap_count`=1, `lap_time`→0.
- **Out-of-order checkpoints.** cp0 then cp2 then finish. Required: `next_cp`=1 at finish, `lap_finished` with `checkpoints_passed`=0, `lap_count`=0, `best_lap`=16'hFFFF.
- **Timeout.** No finish for 80 cycles after start. Required: `max_lap_time_exceeded` for 1 cycle, `lap_time`=20, state ARMED. A later cp edge does not move `next_cp`.
- **Held and simultaneous inputs.** Hold `finish_hit` high for 50 cycles: one `lap_finished` only. Assert finish and the expected cp in the same cycle: the cp is discarded and `next_cp`=0.
- **Best-lap retention.** Valid laps of 15 then 9 then 18: `best_lap`=15, then 9, then 9. Drop `race_active`: counters clear, `best_lap` stays 9.
- **Mid-lap reset.** Assert `rst` mid-lap: all outputs return to their reset values the next cycle, `best_lap`=16'hFFFF.
